bus_slave_port: RTL and testbench

//  Slave-end endpoint of the serial system bus. It receives the per-slave signals from the bus mux
//  (valid, serial address, serial write data, write_en/read_en) and executes the transfer against a

---
 rtl/bus_slave_port_if.sv | 20 ++
 rtl/bus_slave_port.sv | 135 +++++++++++++
 tb/tb_bus_slave_port.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_port_if.sv
// Per-slave serial bus signal group between the bus mux (master side) and one slave endpoint.
interface bus_slave_port_if;
    logic valid;
    logic rx_address;
    logic rx_data;
    logic write_en;
    logic read_en;
    logic tx_data;
    logic slave_ready;

    modport master (
        output valid, rx_address, rx_data, write_en, read_en,
        input  tx_data, slave_ready
    );

    modport slave (
        input  valid, rx_address, rx_data, write_en, read_en,
        output tx_data, slave_ready
    );
endinterface

// File: rtl/bus_slave_port.sv
// Serial bus slave endpoint: shifts in address/write data LSB first, executes the transfer
// against a local word memory and shifts read data out on tx_data.
module bus_slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic             clk,
    input  logic             rst,
    bus_slave_port_if.slave  bus
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int MW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CW-1:0]         ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0]         DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_WDATA   = 3'd2;
    localparam logic [2:0] S_WCOMMIT = 3'd3;
    localparam logic [2:0] S_RWAIT   = 3'd4;
    localparam logic [2:0] S_RDATA   = 3'd5;

    logic [2:0]            state;
    logic [CW-1:0]         count;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [DATA_WIDTH-1:0] wdata_sr;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic          no_sel;
    logic          one_sel;
    logic          in_range;
    logic [MW-1:0] mem_idx;

    assign no_sel   = !bus.write_en && !bus.read_en;
    assign one_sel  = bus.write_en ^ bus.read_en;
    assign in_range = ({1'b0, addr_sr} < DEPTH_LIM);
    assign mem_idx  = addr_sr[MW-1:0];

    assign bus.slave_ready = (state == S_IDLE);
    assign bus.tx_data     = (state == S_RDATA) ? tx_sr[0] : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            count    <= '0;
            is_write <= 1'b0;
            tx_sr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.valid && one_sel) begin
                        addr_sr  <= {bus.rx_address, addr_sr[ADDR_WIDTH-1:1]};
                        is_write <= bus.write_en;
                        count    <= CW'(1);
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (no_sel) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else if (bus.valid) begin
                        addr_sr <= {bus.rx_address, addr_sr[ADDR_WIDTH-1:1]};
                        if (count == ADDR_LAST) begin
                            count <= '0;
                            state <= is_write ? S_WDATA : S_RWAIT;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                S_WDATA: begin
                    if (no_sel) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else if (bus.valid) begin
                        wdata_sr <= {bus.rx_data, wdata_sr[DATA_WIDTH-1:1]};
                        if (count == DATA_LAST) begin
                            count <= '0;
                            state <= S_WCOMMIT;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                S_WCOMMIT: begin
                    state <= S_IDLE;
                end
                S_RWAIT: begin
                    if (no_sel) begin
                        state <= S_IDLE;
                    end else begin
                        // Out-of-range reads still take the full data phase, returning zeros.
                        tx_sr <= in_range ? mem[mem_idx] : '0;
                        count <= '0;
                        state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (no_sel) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else if (bus.valid) begin
                        tx_sr <= {1'b0, tx_sr[DATA_WIDTH-1:1]};
                        if (count == DATA_LAST) begin
                            count <= '0;
                            state <= S_IDLE;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: begin
                    count <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory is never reset; a reset edge only suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (rst && state == S_WCOMMIT && in_range) begin
            mem[mem_idx] <= wdata_sr;
        end
    end

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed plus randomized checks of bus_slave_port against a word-level memory model.
module tb_bus_slave_port;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_slave_port_if bus ();

    bus_slave_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] ref_mem [int];
    int            written [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_read(input int addr);
        if (addr >= DEPTH) return '0;
        return ref_mem[addr];
    endfunction

    task automatic pause(input int n, input logic exp_tx, input string tag);
        for (int k = 0; k < n; k++) begin
            bus.valid = 1'b0;
            step();
            check({tag, "_pause_ready"}, bus.slave_ready, 1'b0);
            check({tag, "_pause_tx"}, bus.tx_data, exp_tx);
        end
    endtask

    task automatic send_addr(input logic [AW-1:0] addr, input int pa_at, input int pa_n, input string tag);
        for (int i = 0; i < AW; i++) begin
            if (i == pa_at && i > 0) pause(pa_n, 1'b0, tag);
            bus.valid      = 1'b1;
            bus.rx_address = addr[i];
            step();
            check({tag, "_addr_ready"}, bus.slave_ready, 1'b0);
            check({tag, "_addr_tx"}, bus.tx_data, 1'b0);
        end
    endtask

    // abort_bit < 0: full write; otherwise both enables drop before that data bit.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int pa_at, input int pa_n, input int pd_at, input int pd_n,
                            input int abort_bit, input string tag);
        bus.write_en = 1'b1;
        bus.read_en  = 1'b0;
        send_addr(addr, pa_at, pa_n, tag);
        for (int i = 0; i < DW; i++) begin
            if (i == abort_bit) begin
                bus.write_en = 1'b0;
                bus.valid    = 1'b1;
                step();
                check({tag, "_abort_ready"}, bus.slave_ready, 1'b1);
                check({tag, "_abort_tx"}, bus.tx_data, 1'b0);
                bus.valid = 1'b0;
                return;
            end
            if (i == pd_at) pause(pd_n, 1'b0, tag);
            bus.valid   = 1'b1;
            bus.rx_data = data[i];
            step();
            check({tag, "_wdata_ready"}, bus.slave_ready, 1'b0);
        end
        bus.valid = 1'b0;
        step();
        check({tag, "_commit_ready"}, bus.slave_ready, 1'b1);
        bus.write_en = 1'b0;
        if (int'(addr) < DEPTH) begin
            ref_mem[int'(addr)] = data;
            written.push_back(int'(addr));
        end
    endtask

    // abort_bit >= 0 ends the read before that bit: by reset if use_rst, else by dropping enables.
    task automatic do_read(input logic [AW-1:0] addr, input int pa_at, input int pa_n,
                           input int pd_at, input int pd_n, input int abort_bit,
                           input bit use_rst, input string tag);
        logic [DW-1:0] exp;
        logic [DW-1:0] got;
        exp = model_read(int'(addr));
        got = '0;
        bus.read_en  = 1'b1;
        bus.write_en = 1'b0;
        send_addr(addr, pa_at, pa_n, tag);
        bus.valid = 1'b0;
        step();
        for (int i = 0; i < DW; i++) begin
            if (i == abort_bit) begin
                if (use_rst) rst = 1'b0;
                else bus.read_en = 1'b0;
                bus.valid = 1'b1;
                step();
                check({tag, "_abort_ready"}, bus.slave_ready, 1'b1);
                check({tag, "_abort_tx"}, bus.tx_data, 1'b0);
                rst          = 1'b1;
                bus.read_en  = 1'b0;
                bus.valid    = 1'b0;
                return;
            end
            got[i] = bus.tx_data;
            check($sformatf("%s_rbit%0d", tag, i), bus.tx_data, exp[i]);
            check({tag, "_rdata_ready"}, bus.slave_ready, 1'b0);
            if (i == pd_at) pause(pd_n, exp[i], tag);
            bus.valid = 1'b1;
            step();
        end
        check({tag, "_rword"}, got, exp);
        check({tag, "_rdone_ready"}, bus.slave_ready, 1'b1);
        check({tag, "_rdone_tx"}, bus.tx_data, 1'b0);
        bus.valid   = 1'b0;
        bus.read_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            op;

        rst            = 1'b0;
        bus.valid      = 1'b0;
        bus.rx_address = 1'b0;
        bus.rx_data    = 1'b0;
        bus.write_en   = 1'b0;
        bus.read_en    = 1'b0;
        step();
        step();
        check("reset_ready", bus.slave_ready, 1'b1);
        check("reset_tx", bus.tx_data, 1'b0);
        rst = 1'b1;
        step();

        // Directed cases
        do_write(12'h123, 8'hA5, -1, 0, -1, 0, -1, "c1_wr");
        do_read (12'h123, -1, 0, -1, 0, -1, 1'b0, "c2_rd");
        do_write(12'h234, 8'h3C, 5, 3, 4, 2, -1, "c3_wr");
        do_read (12'h234, -1, 0, -1, 0, -1, 1'b0, "c3_rd");
        do_write(12'h010, 8'h5A, -1, 0, -1, 0, -1, "c4_pre");
        do_write(12'h010, 8'hFF, -1, 0, -1, 0, 4, "c4_abort");
        do_read (12'h010, -1, 0, -1, 0, -1, 1'b0, "c4_rd");
        do_write(12'h900, 8'h77, -1, 0, -1, 0, -1, "c5_wr");
        do_read (12'h900, -1, 0, -1, 0, -1, 1'b0, "c5_rd");
        do_read (12'h123, -1, 0, -1, 0, 3, 1'b1, "c6_rst");
        do_read (12'h123, -1, 0, -1, 0, 5, 1'b0, "rd_abort");

        bus.valid      = 1'b1;
        bus.write_en   = 1'b1;
        bus.read_en    = 1'b1;
        bus.rx_address = 1'b1;
        step();
        check("both_en_ready0", bus.slave_ready, 1'b1);
        step();
        check("both_en_ready1", bus.slave_ready, 1'b1);
        bus.valid    = 1'b0;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        step();
        do_read(12'h123, -1, 0, -1, 0, -1, 1'b0, "post_rst_rd");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            op = int'($urandom_range(0, 2));
            d  = DW'($urandom);
            if (op != 0) begin
                a = AW'($urandom);
                do_write(a, d, int'($urandom_range(1, AW-1)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, DW-1)), int'($urandom_range(0, 3)), -1, "rnd_wr");
            end else begin
                if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(DEPTH, (1 << AW) - 1));
                else a = AW'(written[$urandom_range(0, written.size() - 1)]);
                do_read(a, int'($urandom_range(1, AW-1)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, DW-1)), int'($urandom_range(0, 3)), -1, 1'b0, "rnd_rd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
